// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (MULT/MULTU/DIV/DIVU) as presented on the op port
//   - FSM state encodings
//   - default operand width
//   - two's-complement negate helper at operand width
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } mdu_state_e;

  function automatic logic [MDU_WIDTH-1:0] twos_neg(input logic [MDU_WIDTH-1:0] x);
    return ~x + MDU_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit holding the HI/LO registers.
// Signed operands are reduced to magnitudes on launch, the unsigned core runs
// one bit per cycle (shift-add multiply or restoring divide), and the sign
// correction is applied when HI/LO are written.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, op       launch request (sampled in IDLE only) and operation code
//   rs_val, rt_val  multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we    MTHI/MTLO strobes (IDLE only, lose to start)
//   wdata           MTHI/MTLO data
//   busy            operation in progress (pipeline stall)
//   done            one-cycle pulse when HI/LO take a new result
//   hi, lo          HI/LO registers
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,  // must equal MDU_WIDTH (negate helper width)
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW = 2 * WIDTH;

  mdu_state_e       state_reg;
  mdu_op_e          op_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [DW-1:0]    acc_reg;    // product being built
  logic [WIDTH-1:0] rem_reg;    // partial remainder (always below the divisor)
  logic [WIDTH-1:0] opa_reg;    // |multiplicand| or dividend/quotient shift register
  logic [WIDTH-1:0] opb_reg;    // |multiplier| (shifted out) or |divisor| (held)
  logic             neg_q_reg;  // product/quotient must be negated
  logic             neg_r_reg;  // remainder must be negated (dividend sign)

  // Launch-time operand conditioning
  logic in_signed, sa, sb;
  always_comb begin
    in_signed = (op == OP_MULT) || (op == OP_DIV);
    sa        = in_signed & rs_val[WIDTH-1];
    sb        = in_signed & rt_val[WIDTH-1];
  end

  // One iteration of each datapath
  logic             is_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;  // 33-bit trial remainder
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  always_comb begin
    is_div    = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
    mul_sum   = {1'b0, acc_reg[DW-1:WIDTH]} + {1'b0, (opb_reg[0] ? opa_reg : '0)};
    div_shift = {rem_reg, opa_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_reg});
    // Only used when div_ge, so the true difference fits in WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - opb_reg;
  end

  // Sign correction for the final write
  logic [WIDTH-1:0] fin_hi, fin_lo;
  logic [DW-1:0]    prod_neg;
  always_comb begin
    // -{H,L} = {-H - (L != 0), -L}
    prod_neg = {twos_neg(acc_reg[DW-1:WIDTH]) - WIDTH'(acc_reg[WIDTH-1:0] != '0),
                twos_neg(acc_reg[WIDTH-1:0])};
    if (is_div) begin
      // Divide by zero: quotient all ones, remainder is the dividend (the
      // restoring loop already leaves |dividend| in rem_reg).
      fin_lo = (opb_reg == '0) ? '1 : (neg_q_reg ? twos_neg(opa_reg) : opa_reg);
      fin_hi = neg_r_reg ? twos_neg(rem_reg) : rem_reg;
    end else begin
      fin_hi = neg_q_reg ? prod_neg[DW-1:WIDTH] : acc_reg[DW-1:WIDTH];
      fin_lo = neg_q_reg ? prod_neg[WIDTH-1:0]  : acc_reg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      op_reg    <= OP_MULT;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg    <= mdu_op_e'(op);
            opa_reg   <= sa ? twos_neg(rs_val) : rs_val;
            opb_reg   <= sb ? twos_neg(rt_val) : rt_val;
            neg_q_reg <= sa ^ sb;
            neg_r_reg <= sa;
            acc_reg   <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= S_RUN;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          if (is_div) begin
            rem_reg <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            opa_reg <= {opa_reg[WIDTH-2:0], div_ge};
          end else begin
            acc_reg <= {mul_sum, acc_reg[WIDTH-1:1]};
            opb_reg <= opb_reg >> 1;
          end
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= S_FIN;
        end
        S_FIN: begin
          hi        <= fin_hi;
          lo        <= fin_lo;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_iterative dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) until busy drops.
  // nb = number of sampled cycles with busy high, ov = cycles with busy&done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int nb, output int ov);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0; ov = 0;
    while (busy && nb < 100) begin
      nb++;
      if (done) ov++;
      @(posedge clk); #1;
    end
    $display("txn op=%0d rs=%h rt=%h busy_cycles=%0d done=%0b hi=%h lo=%h",
             o, a, b, nb, done, hi, lo);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(posedge clk); #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if ({busy, done, hi, lo} !== 66'h0) begin n_bad++; $display("FAIL idle_after_reset: got %h want 0", {busy, done, hi, lo}); end
  endtask

  task automatic test_multu;
    int nb, ov;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, ov);
    n_cmp++; if (nb !== 33) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 33", nb); end
    n_cmp++; if (ov !== 0) begin n_bad++; $display("FAIL multu_busy_done_overlap: got %0d want 0", ov); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL multu_done: got %b want 1", done); end
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL multu_done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_mult;
    int nb, ov;
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, nb, ov);
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin n_bad++; $display("FAIL mult_neg: got %h want ffffffffffffffeb", {hi, lo}); end
    do_op(2'b00, 32'h80000000, 32'h80000000, nb, ov);
    n_cmp++; if ({hi, lo} !== 64'h40000000_00000000) begin n_bad++; $display("FAIL mult_minmin: got %h want 4000000000000000", {hi, lo}); end
    n_cmp++; if (nb !== 33 || done !== 1'b1) begin n_bad++; $display("FAIL mult_timing: got busy=%0d done=%b want 33/1", nb, done); end
  endtask

  task automatic test_div;
    int nb, ov;
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, nb, ov);
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    do_op(2'b11, 32'd100, 32'd7, nb, ov);
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL divu_100_7: got hi=%0d lo=%0d want 2/14", hi, lo); end
  endtask

  task automatic test_div_boundary;
    int nb, ov;
    do_op(2'b10, 32'd5, 32'd0, nb, ov);
    n_cmp++; if ({hi, lo} !== {32'd5, 32'hFFFFFFFF}) begin n_bad++; $display("FAIL div_by_zero: got hi=%h lo=%h want 00000005/ffffffff", hi, lo); end
    n_cmp++; if (nb !== 33) begin n_bad++; $display("FAIL div_by_zero_cycles: got %0d want 33", nb); end
    do_op(2'b10, 32'hFFFFFFF6, 32'd0, nb, ov);
    n_cmp++; if ({hi, lo} !== {32'hFFFFFFF6, 32'hFFFFFFFF}) begin n_bad++; $display("FAIL div_neg_by_zero: got hi=%h lo=%h want fffffff6/ffffffff", hi, lo); end
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, nb, ov);
    n_cmp++; if ({hi, lo} !== {32'h0, 32'h80000000}) begin n_bad++; $display("FAIL div_overflow: got hi=%h lo=%h want 00000000/80000000", hi, lo); end
  endtask

  task automatic test_busy_strobes;
    int nb, ov;
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0; ov = 0;
    while (busy && nb < 100) begin
      nb++;
      if (nb == 5) begin
        start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3;
      end else if (nb == 6) begin
        start = 1'b0; hi_we = 1'b1; wdata = 32'h0000DEAD;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (done) ov++;
      @(posedge clk); #1;
    end
    start = 1'b0; hi_we = 1'b0;
    $display("txn divu 100/7 with start+mthi while busy: busy_cycles=%0d hi=%h lo=%h", nb, hi, lo);
    n_cmp++; if (nb !== 33) begin n_bad++; $display("FAIL busy_ignore_cycles: got %0d want 33", nb); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL busy_ignore_result: got hi=%h lo=%h want 2/14", hi, lo); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_no_restart: got %b want 0", busy); end

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    $display("txn mthi+mtlo wdata=00001234 hi=%h lo=%h", hi, lo);
    n_cmp++; if ({hi, lo} !== {32'h1234, 32'h1234}) begin n_bad++; $display("FAIL mthi_mtlo: got hi=%h lo=%h want 1234/1234", hi, lo); end

    op = 2'b11; rs_val = 32'd9; rt_val = 32'd3; start = 1'b1; lo_we = 1'b1; wdata = 32'h5555;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    $display("txn divu 9/3 with mtlo in start cycle: busy=%b lo=%h", busy, lo);
    n_cmp++; if ({busy, lo} !== {1'b1, 32'h1234}) begin n_bad++; $display("FAIL start_beats_mtlo: got busy=%b lo=%h want 1/00001234", busy, lo); end
    nb = 0;
    while (busy && nb < 100) begin nb++; @(posedge clk); #1; end
    n_cmp++; if ({done, hi, lo} !== {1'b1, 32'd0, 32'd3}) begin n_bad++; $display("FAIL divu_9_3: got done=%b hi=%h lo=%h want 1/0/3", done, hi, lo); end
  endtask

  task automatic test_reset_midop;
    int nb, ov, ndone, nbusy;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b01; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_cmp++; if ({busy, hi, lo} !== {1'b1, 32'h1234, 32'h1234}) begin n_bad++; $display("FAIL hold_during_run: got busy=%b hi=%h lo=%h want 1/1234/1234", busy, hi, lo); end
    #2 rst = 1'b1;
    #1;
    $display("txn async reset mid-multu: busy=%b hi=%h lo=%h", busy, hi, lo);
    n_cmp++; if ({busy, done, hi, lo} !== 66'h0) begin n_bad++; $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo); end
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (40) begin
      if (done) ndone++;
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
    n_cmp++; if ({ndone, nbusy} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL no_done_after_reset: got done=%0d busy=%0d want 0/0", ndone, nbusy); end
    do_op(2'b11, 32'd9, 32'd3, nb, ov);
    n_cmp++; if ({nb, done, hi, lo} !== {32'd33, 1'b1, 32'd0, 32'd3}) begin n_bad++; $display("FAIL divu_after_reset: got busy=%0d done=%b hi=%h lo=%h want 33/1/0/3", nb, done, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_boundary();
    test_busy_strobes();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
